// File: rtl/dft_arb_pkg.sv
// dft_arb_pkg: shared states, error bit indices and legal LTE DFT sizes
package dft_arb_pkg;
  typedef enum logic [2:0] {S_IDLE, S_XFER, S_PAD, S_DROP, S_GAP} state_t;
  localparam int ERR_SHORT  = 0;
  localparam int ERR_LONG   = 1;
  localparam int ERR_SIZE   = 2;
  localparam int ERR_ORPHAN = 3;
  localparam int N_LTE = 34;
  localparam logic [11:0] LTE_SIZES [N_LTE] = '{
    12'd12,  12'd24,  12'd36,  12'd48,  12'd60,  12'd72,  12'd96,  12'd108,
    12'd120, 12'd144, 12'd180, 12'd192, 12'd216, 12'd240, 12'd288, 12'd300,
    12'd324, 12'd360, 12'd384, 12'd432, 12'd480, 12'd540, 12'd576, 12'd600,
    12'd648, 12'd720, 12'd768, 12'd864, 12'd900, 12'd960, 12'd972, 12'd1080,
    12'd1152, 12'd1200
  };
endpackage

// File: rtl/dft_size_check.sv
// dft_size_check: flags whether a frame size is one of the legal LTE DFT sizes
module dft_size_check import dft_arb_pkg::*; #(
  parameter int PW = 12
) (
  input  logic [PW-1:0] dftpts_i,
  output logic          legal_o
);
  // linear match against the size table
  always_comb begin
    legal_o = 1'b0;
    for (int k = 0; k < N_LTE; k++) legal_o |= (32'(dftpts_i) == 32'(LTE_SIZES[k]));
  end
endmodule

// File: rtl/dft_frame_arbiter.sv
// dft_frame_arbiter: frame-granular round-robin share of one DFT core; DFT_ARB_GAP_EN adds a post-frame idle gap
module dft_frame_arbiter import dft_arb_pkg::*; #(
  parameter int N_REQ   = 2,
  parameter int DW      = 18,
  parameter int PW      = 12,
  parameter int MIN_GAP = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ-1:0]   req_sop,
  input  logic [N_REQ-1:0]   req_eop,
  input  logic [N_REQ*DW-1:0] req_real,
  input  logic [N_REQ*DW-1:0] req_imag,
  input  logic [N_REQ*PW-1:0] req_dftpts,
  input  logic [N_REQ-1:0]   req_inverse,
  output logic               dft_valid,
  input  logic               dft_ready,
  output logic               dft_sop,
  output logic               dft_eop,
  output logic [DW-1:0]      dft_real,
  output logic [DW-1:0]      dft_imag,
  output logic [PW-1:0]      dft_dftpts,
  output logic               dft_inverse,
  output logic [1:0]         grant_id,
  output logic [3:0]         err
);
`ifdef DFT_ARB_GAP_EN
  localparam state_t END_ST = S_GAP;
`else
  localparam state_t END_ST = S_IDLE;
`endif
  state_t state_q, state_d;
  logic [1:0] rr_q, rr_d, grant_q, grant_d, pick;
  logic [PW-1:0] pts_q, pts_d, cnt_q, cnt_d, sel_pts;
  logic inv_q, inv_d, found, legal, last;
  logic [3:0] err_q, err_d;
  logic [N_REQ-1:0] cand;
  int gi;
  assign cand = req_valid & req_sop;
  assign gi = int'(grant_q);
  assign last = (cnt_q == pts_q - PW'(1));
  assign sel_pts = req_dftpts[int'(pick)*PW +: PW];
  assign grant_id = grant_q;
  assign dft_dftpts = pts_q;
  assign dft_inverse = inv_q;
  assign err = err_q;

  dft_size_check #(.PW(PW)) u_size (.dftpts_i(sel_pts), .legal_o(legal));

  // round-robin search for the first sop candidate at or after rr_ptr
  always_comb begin
    found = 1'b0;
    pick = '0;
    for (int k = 0; k < N_REQ; k++)
      if (!found && cand[(int'(rr_q) + k) % N_REQ]) begin
        found = 1'b1;
        pick = 2'((int'(rr_q) + k) % N_REQ);
      end
  end

  // next state, core-side mux and requester handshakes
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    grant_d = grant_q;
    pts_d = pts_q;
    inv_d = inv_q;
    cnt_d = cnt_q;
    err_d = '0;
    req_ready = '0;
    dft_valid = 1'b0;
    dft_sop = 1'b0;
    dft_eop = 1'b0;
    dft_real = '0;
    dft_imag = '0;
    case (state_q)
      S_IDLE: begin
        req_ready = req_valid & ~req_sop;
        err_d[ERR_ORPHAN] = |req_ready;
        if (found) begin
          grant_d = pick;
          pts_d = sel_pts;
          inv_d = req_inverse[int'(pick)];
          cnt_d = '0;
          rr_d = (int'(pick) == N_REQ - 1) ? 2'd0 : pick + 2'd1;
          state_d = legal ? S_XFER : S_DROP;
          err_d[ERR_SIZE] = ~legal;
        end
      end
      S_XFER: begin
        dft_valid = req_valid[gi];
        req_ready[gi] = dft_ready;
        dft_sop = (cnt_q == '0);
        dft_eop = last;
        dft_real = req_real[gi*DW +: DW];
        dft_imag = req_imag[gi*DW +: DW];
        if (dft_valid && dft_ready) begin
          cnt_d = cnt_q + PW'(1);
          if (last) begin
            state_d = req_eop[gi] ? END_ST : S_DROP;
            err_d[ERR_LONG] = ~req_eop[gi];
            cnt_d = '0;
          end else if (req_eop[gi]) begin
            state_d = S_PAD;
            err_d[ERR_SHORT] = 1'b1;
          end
        end
      end
      S_PAD: begin
        dft_valid = 1'b1;
        dft_eop = last;
        if (dft_ready) begin
          cnt_d = last ? '0 : cnt_q + PW'(1);
          state_d = last ? END_ST : S_PAD;
        end
      end
      S_DROP: begin
        req_ready[gi] = 1'b1;
        if (req_valid[gi] && req_eop[gi]) begin
          state_d = END_ST;
          cnt_d = '0;
        end
      end
      S_GAP: begin
        cnt_d = cnt_q + PW'(1);
        state_d = (cnt_q == PW'(MIN_GAP - 1)) ? S_IDLE : S_GAP;
      end
      default: state_d = S_IDLE;
    endcase
    if (!rst_n) begin
      req_ready = '0;
      dft_valid = 1'b0;
      dft_sop = 1'b0;
      dft_eop = 1'b0;
    end
  end

  // state and latched frame registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rr_q <= '0;
      grant_q <= '0;
      pts_q <= '0;
      inv_q <= 1'b0;
      cnt_q <= '0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      grant_q <= grant_d;
      pts_q <= pts_d;
      inv_q <= inv_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_dft_frame_arbiter.sv
// tb_dft_frame_arbiter: directed checks of the DFT frame arbiter
module tb_dft_frame_arbiter;
  localparam int N = 2, DW = 18, PW = 12;
  localparam logic [17:0] MASK = 18'h2AAAA;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req_valid, req_ready, req_sop, req_eop, req_inverse;
  logic [N*DW-1:0] req_real, req_imag;
  logic [N*PW-1:0] req_dftpts;
  logic dft_valid, dft_ready, dft_sop, dft_eop, dft_inverse;
  logic [DW-1:0] dft_real, dft_imag;
  logic [PW-1:0] dft_dftpts;
  logic [1:0] grant_id;
  logic [3:0] err;
  int n_chk = 0, n_fail = 0;
  int cfg_pts [N] = '{0, 0};
  int cfg_len [N] = '{1, 1};
  int cfg_reps [N] = '{0, 0};
  bit cfg_inv [N] = '{0, 0};
  bit cfg_nosop [N] = '{0, 0};
  int go [N] = '{0, 0};
  bit cfg_kill = 1'b0, rnd = 1'b0;
  bit active [N] = '{0, 0};
  int beat [N] = '{0, 0};
  int fseq [N] = '{0, 0};
  int reps [N] = '{0, 0};
  int seen [N] = '{0, 0};
  logic [N-1:0] acc_s = '0;
  int cyc = 0, fbeat = 0, m_beats = 0, m_sop = 0, m_eop = 0, m_eop_pos = 0, m_data = 0, m_proto = 0;
  int m_err [4] = '{0, 0, 0, 0};
  int m_order [$], m_sop_cyc [$], m_eop_cyc [$];
  bit in_frame = 1'b0;
  int b_beats, b_sop, b_eop, b_data, b_proto;
  int b_err [4];

  dft_frame_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_sop(req_sop), .req_eop(req_eop), .req_real(req_real), .req_imag(req_imag),
    .req_dftpts(req_dftpts), .req_inverse(req_inverse), .dft_valid(dft_valid),
    .dft_ready(dft_ready), .dft_sop(dft_sop), .dft_eop(dft_eop), .dft_real(dft_real),
    .dft_imag(dft_imag), .dft_dftpts(dft_dftpts), .dft_inverse(dft_inverse),
    .grant_id(grant_id), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] enc(input int i, input int f, input int b);
    return {i[1:0], f[4:0], b[10:0]};
  endfunction

  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic start(input int i, input int pts, input int len, input bit inv, input int rp, input bit nosop);
    cfg_pts[i] = pts;
    cfg_len[i] = len;
    cfg_inv[i] = inv;
    cfg_reps[i] = rp;
    cfg_nosop[i] = nosop;
    go[i]++;
  endtask

  task automatic snap;
    b_beats = m_beats;
    b_sop = m_sop;
    b_eop = m_eop;
    b_data = m_data;
    b_proto = m_proto;
    for (int b = 0; b < 4; b++) b_err[b] = m_err[b];
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    cfg_kill = 1'b1;
    repeat (3) tick;
    rst_n = 1'b1;
    cfg_kill = 1'b0;
    tick;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while ((active[0] || active[1] || go[0] != seen[0] || go[1] != seen[1]) && n < budget) begin
      tick;
      n++;
    end
    check({tag, "_timeout"}, n < budget, 1);
    repeat (20) tick;
  endtask

  // requester sources: advance on accepted beats, drive at posedge+1
  initial begin
    req_valid = '0; req_sop = '0; req_eop = '0; req_inverse = '0;
    req_real = '0; req_imag = '0; req_dftpts = '0; dft_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (cfg_kill) active[i] = 1'b0;
        else if (active[i] && acc_s[i]) begin
          beat[i]++;
          if (beat[i] == cfg_len[i]) begin
            fseq[i]++;
            beat[i] = 0;
            if (reps[i] > 0) reps[i]--;
            else active[i] = 1'b0;
          end
        end
        if (!active[i] && !cfg_kill && go[i] != seen[i]) begin
          seen[i] = go[i];
          active[i] = 1'b1;
          beat[i] = 0;
          reps[i] = cfg_reps[i];
        end
        req_valid[i] = active[i];
        req_sop[i] = active[i] && beat[i] == 0 && !cfg_nosop[i];
        req_eop[i] = active[i] && beat[i] == cfg_len[i] - 1;
        req_real[i*DW +: DW] = active[i] ? enc(i, fseq[i], beat[i]) : '0;
        req_imag[i*DW +: DW] = active[i] ? enc(i, fseq[i], beat[i]) ^ MASK : '0;
        req_dftpts[i*PW +: PW] = 12'(cfg_pts[i]);
        req_inverse[i] = cfg_inv[i];
      end
      dft_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // core-side monitor sampled on the falling edge
  always @(negedge clk) begin
    int g;
    logic [17:0] er, ei;
    cyc++;
    acc_s = req_valid & req_ready;
    if (rst_n) begin
      for (int b = 0; b < 4; b++) if (err[b]) m_err[b]++;
      if (dft_valid && dft_ready) begin
        if (dft_sop) begin
          if (in_frame) m_proto++;
          in_frame = 1'b1;
          fbeat = 0;
          m_sop++;
          m_order.push_back(int'(grant_id));
          m_sop_cyc.push_back(cyc);
        end else if (!in_frame) m_proto++;
        fbeat++;
        m_beats++;
        g = int'(grant_id);
        er = (fbeat <= cfg_len[g]) ? enc(g, fseq[g], fbeat - 1) : '0;
        ei = (fbeat <= cfg_len[g]) ? er ^ MASK : '0;
        if (dft_real !== er || dft_imag !== ei) m_data++;
        if (dft_eop) begin
          m_eop++;
          m_eop_pos = fbeat;
          m_eop_cyc.push_back(cyc);
          in_frame = 1'b0;
        end
      end
    end else in_frame = 1'b0;
  end

  initial begin
    repeat (3) tick;
    rst_n = 1'b1;
    tick;
    check("rst_ready", req_ready, 0);
    check("rst_valid", dft_valid, 0);
    check("rst_grant", grant_id, 0);
    check("rst_pts", dft_dftpts, 0);
    check("rst_inv", dft_inverse, 0);
    check("rst_err", err, 0);
    // full 1200-point frame from req0
    do_reset;
    snap;
    start(0, 1200, 1200, 1'b1, 0, 1'b0);
    wait_idle("t1", 3000);
    check("t1_beats", m_beats - b_beats, 1200);
    check("t1_sop", m_sop - b_sop, 1);
    check("t1_eop", m_eop - b_eop, 1);
    check("t1_eop_pos", m_eop_pos, 1200);
    check("t1_data", m_data - b_data, 0);
    check("t1_proto", m_proto - b_proto, 0);
    check("t1_pts", dft_dftpts, 1200);
    check("t1_grant", grant_id, 0);
    check("t1_inv", dft_inverse, 1);
    check("t1_errs", m_err[0] + m_err[1] + m_err[2] + m_err[3] - b_err[0] - b_err[1] - b_err[2] - b_err[3], 0);
    // simultaneous requests alternate
    do_reset;
    snap;
    start(0, 12, 12, 1'b0, 1, 1'b0);
    start(1, 24, 24, 1'b0, 1, 1'b0);
    wait_idle("t2", 2000);
    check("t2_sop", m_sop - b_sop, 4);
    check("t2_beats", m_beats - b_beats, 72);
    check("t2_data", m_data - b_data, 0);
    if (m_sop - b_sop >= 4) begin
      for (int k = 0; k < 4; k++) check($sformatf("t2_order%0d", k), m_order[b_sop + k], k % 2);
      for (int k = 1; k < 4; k++) check($sformatf("t2_gap%0d", k), m_sop_cyc[b_sop + k] - m_eop_cyc[b_eop + k - 1], 2);
    end
    // short frame padded with zeros
    do_reset;
    snap;
    start(1, 36, 30, 1'b0, 0, 1'b0);
    wait_idle("t3", 500);
    check("t3_beats", m_beats - b_beats, 36);
    check("t3_eop_pos", m_eop_pos, 36);
    check("t3_data", m_data - b_data, 0);
    check("t3_err_short", m_err[0] - b_err[0], 1);
    check("t3_err_other", m_err[1] + m_err[2] + m_err[3] - b_err[1] - b_err[2] - b_err[3], 0);
    check("t3_grant", grant_id, 1);
    // long frame truncated and drained
    do_reset;
    snap;
    start(0, 12, 20, 1'b0, 0, 1'b0);
    wait_idle("t4", 500);
    check("t4_beats", m_beats - b_beats, 12);
    check("t4_eop_pos", m_eop_pos, 12);
    check("t4_data", m_data - b_data, 0);
    check("t4_err_long", m_err[1] - b_err[1], 1);
    check("t4_err_short", m_err[0] - b_err[0], 0);
    // illegal sizes dropped, orphan beat in IDLE
    do_reset;
    snap;
    start(0, 1000, 1000, 1'b0, 0, 1'b0);
    wait_idle("t5a", 2000);
    check("t5_beats_a", m_beats - b_beats, 0);
    check("t5_err_size_a", m_err[2] - b_err[2], 1);
    start(1, 1296, 5, 1'b0, 0, 1'b0);
    wait_idle("t5b", 500);
    check("t5_beats_b", m_beats - b_beats, 0);
    check("t5_err_size_b", m_err[2] - b_err[2], 2);
    check("t5_grant", grant_id, 1);
    start(0, 12, 1, 1'b0, 0, 1'b1);
    wait_idle("t5c", 200);
    check("t5_err_orphan", m_err[3] - b_err[3], 1);
    check("t5_beats_c", m_beats - b_beats, 0);
    // random backpressure then reset mid-frame
    do_reset;
    snap;
    rnd = 1'b1;
    start(0, 1200, 1200, 1'b0, 0, 1'b0);
    begin
      int n = 0;
      while (m_beats - b_beats < 500 && n < 5000) begin
        tick;
        n++;
      end
      check("t6_timeout", n < 5000, 1);
    end
    rst_n = 1'b0;
    cfg_kill = 1'b1;
    tick;
    tick;
    check("t6_rst_valid", dft_valid, 0);
    check("t6_rst_ready", req_ready, 0);
    check("t6_rst_grant", grant_id, 0);
    check("t6_rst_pts", dft_dftpts, 0);
    check("t6_beats", m_beats - b_beats, 500);
    check("t6_no_eop", m_eop - b_eop, 0);
    check("t6_data", m_data - b_data, 0);
    rst_n = 1'b1;
    cfg_kill = 1'b0;
    rnd = 1'b0;
    tick;
    snap;
    start(1, 12, 12, 1'b0, 0, 1'b0);
    start(0, 12, 12, 1'b0, 0, 1'b0);
    wait_idle("t6b", 500);
    check("t6_post_beats", m_beats - b_beats, 24);
    if (m_sop - b_sop >= 2) begin
      check("t6_order0", m_order[b_sop], 0);
      check("t6_order1", m_order[b_sop + 1], 1);
    end else check("t6_post_sop", m_sop - b_sop, 2);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dft_frame_arbiter.md
Name: dft_frame_arbiter

Overview:
Frame-granular round-robin arbiter that shares one mixed-radix DFT core (sizes 12..1200, 18-bit I/Q, valid/ready/sop/eop) between N_REQ streaming requesters. It grants the core for a whole frame and latches that frame's dftpts and inverse at grant. It polices frame length against dftpts: short frames are zero-padded and long frames are truncated. Frames with an illegal size are dropped. It sits directly in front of the DFT core sink port.

Parameters:
N_REQ, 2, number of requesters (2..4)
DW, 18, sample width per I/Q component
PW, 12, dftpts width
MIN_GAP, 4, idle cycles enforced after each frame (optional feature only)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low
req_valid  in  N_REQ  per-requester beat valid
req_ready  out  N_REQ  per-requester beat accept
req_sop  in  N_REQ  first beat of frame
req_eop  in  N_REQ  last beat of frame
req_real  in  N_REQ*DW  real samples, requester i at [i*DW +: DW]
req_imag  in  N_REQ*DW  imag samples
req_dftpts  in  N_REQ*PW  frame size, sampled on sop beat
req_inverse  in  N_REQ  IDFT select, sampled on sop beat
dft_valid  out  1  to core sink_valid
dft_ready  in  1  from core sink_ready
dft_sop  out  1  to core
dft_eop  out  1  to core
dft_real  out  DW  to core
dft_imag  out  DW  to core
dft_dftpts  out  PW  latched frame size
dft_inverse  out  1  latched inverse
grant_id  out  2  current/last granted requester
err  out  4  one-cycle pulses: [0] short, [1] long, [2] size, [3] orphan

Behaviour:
- Transfer occurs when valid&ready on either side. cnt (PW bits) counts accepted core beats in the frame.
- States: IDLE, XFER, PAD, DROP (plus GAP if enabled).
- IDLE:
  - Candidates are i with req_valid[i]&req_sop[i]. Pick the first candidate searching from rr_ptr upward with wrap.
  - At the clock edge: register grant_id, latch dftpts/inverse, cnt=0.
  - If size is legal, go to XFER. Otherwise go to DROP and pulse err[2].
  - rr_ptr := grant+1 mod N_REQ. Sizes are checked against the package LTE table.
  - One-cycle arbitration bubble. No beat is accepted in the grant cycle.
  - Any requester with valid&~sop in IDLE gets ready=1: beat discarded, err[3] pulsed.
  - All other req_ready=0.
- XFER:
  - Combinational mux from granted requester. dft_valid=req_valid[g]; req_ready[g]=dft_ready; others 0.
  - dft_sop=(cnt==0).
  - dft_eop=(cnt==dftpts-1), independent of req_eop.
  - req_sop on non-first beats is ignored.
  - Accepted beat with req_eop and cnt<dftpts-1: go to PAD, pulse err[0].
  - Accepted beat with cnt==dftpts-1: if req_eop, go to IDLE; else go to DROP and pulse err[1].
- PAD:
  - dft_valid=1, data=0, req_ready=0.
  - dft_eop on cnt==dftpts-1, then go to IDLE.
- DROP:
  - req_ready[g]=1, dft_valid=0.
  - Exit to IDLE on accepted req_eop.
- Outputs outside XFER/PAD: dft_valid/sop/eop=0, data=0.
- Reset values: state IDLE, rr_ptr 0, grant_id 0, dft_dftpts 0, dft_inverse 0, err 0, all ready 0, dft_valid 0.
- Reset mid-frame: next cycle is IDLE with reset values. No eop is emitted.
- Simultaneous requests: strict round-robin. A requester cannot win twice while another has a pending sop.

Optional Feature:
DFT_ARB_GAP_EN
- Defined: after the frame's final core beat (or DROP exit), enter GAP for MIN_GAP cycles with all ready=0. IDLE arbitration resumes afterward.
- Undefined: IDLE directly, so the next grant edge falls one cycle after eop.

Decomposition:
- Package dft_arb_pkg holds:
  - state enum
  - error bit index constants
  - LTE_SIZES table (34 entries, 12*m for m in 1,2,3,4,5,6,8,9,10,12,15,16,18,20,24,25,27,30,32,36,40,45,48,50,54,60,64,72,75,80,81,90,96,100)
- Sub-module dft_size_check: combinational lookup, dftpts -> legal.

Test Plan:
1. Req0 single frame dftpts=1200, 1200 beats, dft_ready=1 -> 1200 core beats; sop on beat 1, eop on beat 1200; dft_dftpts=1200, grant_id=0, err=0.
2. Req0 and req1 sop in same cycle, dftpts 12 and 24, both re-request -> order req0, req1, req0, req1; one idle cycle before each sop.
3. Req1 dftpts=36, eop on beat 30 -> beats 31-36 zero, dft_eop on beat 36, err[0] pulse once.
4. Req0 dftpts=12, eop on beat 20 -> dft_eop on beat 12; beats 13-20 accepted, not forwarded; err[1] pulse.
5. dftpts=1000 and 1296 -> no dft_valid, whole frame drained, err[2] per frame; orphan beat in IDLE -> err[3].
6. dft_ready 50% random, then rst_n low at beat 500 of a 1200 frame -> data order intact, no drops; after reset, state IDLE and rr_ptr=0.
